instr_fetch_cached: RTL and testbench
=====================================

// Module: instr_fetch_cached
// PURPOSE
//  Parametrised instruction-fetch stage: holds the PC, looks up a direct-mapped instruction cache and refills missing lines from memory.
//  Refill uses a req/ready handshake. Supports branch redirect and pipeline stall.
//  Feeds the decode stage through instr_fetch_out, valid_out and pc_out. Branch resolution comes from EX.
// PARAMETERS
//  ADDR_W    16  PC / memory word-address width
//  INSTR_W   16  instruction width
//  LINES     8   cache lines, power of two
//  WORDS     4   words per line, power of two, >=2
//  RESET_PC  0   PC value after reset
// PORTS
//  clk              in   1        rising-edge clock
//  rst_n            in   1        async active-low reset
//  branch_target    in   ADDR_W   redirect address
//  PC_src           in   1        1 = take branch_target this cycle
//  stall            in   1        1 = decode not ready; hold the fetch stage
//  mem_req          out  1        refill read request
//  mem_addr         out  ADDR_W   refill word address
//  mem_ready        in   1        mem_rdata valid for mem_addr this cycle
//  mem_rdata        in   INSTR_W  refill data
//  instr_fetch_out  out  INSTR_W  fetched instruction (registered)
//  hit_fetch_out    out  1        1 = this output came from a cache hit
//  valid_out        out  1        instr_fetch_out/pc_out are meaningful
//  pc_out           out  ADDR_W   address of instr_fetch_out
// BEHAVIOUR
//  Address split
//   - OFF = log2(WORDS), IDX = log2(LINES), TAG = ADDR_W-IDX-OFF.
//   - Each line holds a valid bit, a TAG-bit tag and WORDS data words.
//  Reset (async, rst_n=0)
//   - State = RUN; PC = RESET_PC; all line valid bits = 0.
//   - mem_req = 0; mem_addr = 0; all outputs = 0; pending branch cleared.
//  State RUN (lookup is combinational on PC; outputs are registered)
//   - stall=1 and PC_src=0: hold PC and all outputs.
//   - PC_src=1 (even with stall): squash the current fetch.
//     valid_out<=0, hit_fetch_out<=0, PC<=branch_target.
//   - Hit, no stall, no PC_src: instr_fetch_out<=word, pc_out<=PC, valid_out<=1, hit_fetch_out<=1.
//     PC<=PC+1, wrapping mod 2^ADDR_W.
//   - Miss, no stall, no PC_src: valid_out<=0, hit_fetch_out<=0.
//     cnt<=0, base<=PC with offset bits zeroed, go to REFILL.
//     PC is unchanged.
//  State REFILL
//   - mem_req=1, mem_addr=base+cnt (registered, consistent in the same cycle).
//   - On mem_ready=1: write mem_rdata into word cnt of line idx(base); cnt++.
//   - On the last word (cnt=WORDS-1 and mem_ready):
//     set valid, write tag, mem_req<=0, go to RUN.
//   - An older valid line at that index is overwritten (conflict eviction).
//   - stall is ignored. valid_out stays 0.
//   - PC_src=1 during REFILL latches branch_target as pending (last one wins).
//   - The refill always completes. On return to RUN, PC<=pending target if one is set, then pending is cleared.
//  Latency
//   - Hit: 1 cycle from PC to output.
//   - Miss: 1 detect cycle + WORDS ready beats + 1 re-lookup cycle.
//  Mid-operation reset
//   - Abort the refill, drop mem_req at once and invalidate every line.
//  Memory handshake
//   - mem_req stays high until the last beat.
//   - mem_ready while mem_req=0 is ignored.
// TESTING
//  Cold start: rst_n released, mem_ready=1, mem_rdata=0x0100+mem_addr.
//   -> mem_addr 0,1,2,3 on consecutive cycles.
//   -> then outputs 0x0100@0, 0x0101@1, 0x0102@2, 0x0103@3 with hit=1 on back-to-back cycles.
//   -> PC=4 misses (valid_out=0, mem_req=1, mem_addr=4).
//  Conflict: after line 0 is filled, PC_src=1 with branch_target=0x0020 (same index, tag 1).
//   -> refill of 0x20..0x23, output 0x0120.
//   -> branch back to 0x0000 misses again.
//  Stall: hit streaming with stall=1 for 3 cycles.
//   -> instr_fetch_out, pc_out and valid_out frozen; resumes at the next PC with no skip or duplicate.
//  Branch in refill: mem_ready pulsed every 2nd cycle; PC_src=1 with target 0x0009 during beat 2.
//   -> refill finishes all 4 words, then next fetch is pc_out=0x0009.
//  Reset mid-refill: rst_n=0 after 2 beats.
//   -> mem_req=0 immediately.
//   -> after release, address 0 misses again (line invalid).
//  Wrap: PC=0xFFFF hit -> next pc_out=0x0000.

Source files
------------

// File: rtl/instr_fetch_cached_if.sv
// Refill bus between the fetch stage (master) and instruction memory (slave).
interface instr_fetch_cached_if #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned INSTR_W = 16
);
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ready;
    logic [INSTR_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/instr_fetch_cached.sv
// Instruction fetch stage with a direct-mapped instruction cache and
// line refill over a req/ready bus; supports branch redirect and stall.
module instr_fetch_cached #(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       INSTR_W  = 16,
    parameter int unsigned       LINES    = 8,
    parameter int unsigned       WORDS    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    branch_target,
    input  logic                 PC_src,
    input  logic                 stall,
    instr_fetch_cached_if.master mem,
    output logic [INSTR_W-1:0]   instr_fetch_out,
    output logic                 hit_fetch_out,
    output logic                 valid_out,
    output logic [ADDR_W-1:0]    pc_out
);
    localparam int unsigned OFF = $clog2(WORDS);
    localparam int unsigned IDX = $clog2(LINES);
    localparam int unsigned TAG = ADDR_W - IDX - OFF;

    typedef enum logic {StRun, StRefill} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [OFF-1:0]      cnt_q, cnt_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                pend_q, pend_d;
    logic [ADDR_W-1:0]   pend_pc_q, pend_pc_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [ADDR_W-1:0]   pc_out_q, pc_out_d;
    logic                valid_q, valid_d;
    logic                hit_q, hit_d;

    logic [LINES-1:0]    line_valid_q;
    logic [TAG-1:0]      tag_q  [LINES];
    logic [INSTR_W-1:0]  data_q [LINES*WORDS];

    logic [IDX-1:0]      pc_idx, base_idx;
    logic [TAG-1:0]      pc_tag, base_tag;
    logic                lookup_hit;
    logic                fill_we;
    logic                fill_last;
    logic [ADDR_W-1:0]   line_base;

    assign pc_idx     = pc_q[OFF +: IDX];
    assign pc_tag     = pc_q[ADDR_W-1 -: TAG];
    assign base_idx   = base_q[OFF +: IDX];
    assign base_tag   = base_q[ADDR_W-1 -: TAG];
    assign line_base  = {pc_q[ADDR_W-1:OFF], {OFF{1'b0}}};
    assign lookup_hit = line_valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign fill_we    = (state_q == StRefill) && mem.mem_ready;
    // WORDS is a power of two, so an all-ones counter marks the final beat.
    assign fill_last  = fill_we && (&cnt_q);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        base_d     = base_q;
        cnt_d      = cnt_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        pend_d     = pend_q;
        pend_pc_d  = pend_pc_q;
        instr_d    = instr_q;
        pc_out_d   = pc_out_q;
        valid_d    = valid_q;
        hit_d      = hit_q;
        unique case (state_q)
            StRun: begin
                if (PC_src) begin
                    valid_d = 1'b0;
                    hit_d   = 1'b0;
                    pc_d    = branch_target;
                end else if (!stall) begin
                    if (lookup_hit) begin
                        instr_d  = data_q[{pc_idx, pc_q[OFF-1:0]}];
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        hit_d    = 1'b1;
                        pc_d     = pc_q + ADDR_W'(1);
                    end else begin
                        valid_d    = 1'b0;
                        hit_d      = 1'b0;
                        cnt_d      = '0;
                        base_d     = line_base;
                        mem_req_d  = 1'b1;
                        mem_addr_d = line_base;
                        state_d    = StRefill;
                    end
                end
            end
            StRefill: begin
                // Redirects during refill are deferred; the newest one wins.
                if (PC_src) begin
                    pend_d    = 1'b1;
                    pend_pc_d = branch_target;
                end
                if (mem.mem_ready) begin
                    if (&cnt_q) begin
                        mem_req_d = 1'b0;
                        state_d   = StRun;
                        pend_d    = 1'b0;
                        if (PC_src) begin
                            pc_d = branch_target;
                        end else if (pend_q) begin
                            pc_d = pend_pc_q;
                        end
                    end else begin
                        cnt_d      = cnt_q + OFF'(1);
                        mem_addr_d = {base_q[ADDR_W-1:OFF], cnt_q + OFF'(1)};
                    end
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StRun;
            pc_q         <= RESET_PC;
            base_q       <= '0;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            pend_q       <= 1'b0;
            pend_pc_q    <= '0;
            instr_q      <= '0;
            pc_out_q     <= '0;
            valid_q      <= 1'b0;
            hit_q        <= 1'b0;
            line_valid_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            pend_q     <= pend_d;
            pend_pc_q  <= pend_pc_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            valid_q    <= valid_d;
            hit_q      <= hit_d;
            if (fill_last) begin
                line_valid_q[base_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays need no reset: the line valid bits guard them.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_q[{base_idx, cnt_q}] <= mem.mem_rdata;
        end
        if (fill_last) begin
            tag_q[base_idx] <= base_tag;
        end
    end

    assign mem.mem_req      = mem_req_q;
    assign mem.mem_addr     = mem_addr_q;
    assign instr_fetch_out  = instr_q;
    assign hit_fetch_out    = hit_q;
    assign valid_out        = valid_q;
    assign pc_out           = pc_out_q;
endmodule

// File: tb/tb_instr_fetch_cached.sv
// Bench for instr_fetch_cached: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural cache/fetch model.
module tb_instr_fetch_cached;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] branch_target;
    logic        pc_src;
    logic        stall;
    logic        mem_ready;
    logic [15:0] instr_fetch_out;
    logic        hit_fetch_out;
    logic        valid_out;
    logic [15:0] pc_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    instr_fetch_cached_if #(.ADDR_W(16), .INSTR_W(16)) bus ();

    // Memory returns address + 0x0100 for every word.
    assign bus.mem_ready = mem_ready;
    assign bus.mem_rdata = bus.mem_addr + 16'h0100;

    instr_fetch_cached #(
        .ADDR_W  (16),
        .INSTR_W (16),
        .LINES   (8),
        .WORDS   (4),
        .RESET_PC(16'h0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .branch_target  (branch_target),
        .PC_src         (pc_src),
        .stall          (stall),
        .mem            (bus),
        .instr_fetch_out(instr_fetch_out),
        .hit_fetch_out  (hit_fetch_out),
        .valid_out      (valid_out),
        .pc_out         (pc_out)
    );

    // Behavioural model: cache contents as plain arrays, refill as a beat count.
    bit          c_valid [8];
    logic [10:0] c_tag   [8];
    logic [15:0] c_word  [8][4];
    bit          m_refill;
    int          m_beats;
    logic [15:0] m_base, m_pc, m_pend_pc;
    bit          m_pend;
    logic [15:0] m_instr, m_pcout, m_addr;
    bit          m_valid, m_hit, m_req;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) c_valid[i] = 1'b0;
        m_refill = 0; m_beats = 0; m_base = 0; m_pc = 0; m_pend = 0; m_pend_pc = 0;
        m_instr = 0; m_pcout = 0; m_addr = 0; m_valid = 0; m_hit = 0; m_req = 0;
    endfunction

    function automatic void model_edge();
        int line;
        line = m_pc / 4 % 8;
        if (!m_refill) begin
            if (pc_src) begin
                m_valid = 0; m_hit = 0; m_pc = branch_target;
            end else if (!stall) begin
                if (c_valid[line] && c_tag[line] == m_pc / 32) begin
                    m_instr = c_word[line][m_pc % 4];
                    m_pcout = m_pc; m_valid = 1; m_hit = 1;
                    m_pc = m_pc + 16'd1;
                end else begin
                    m_valid = 0; m_hit = 0;
                    m_refill = 1; m_beats = 0;
                    m_base = m_pc - (m_pc % 4);
                    m_req = 1; m_addr = m_base;
                end
            end
        end else begin
            if (pc_src) begin
                m_pend = 1; m_pend_pc = branch_target;
            end
            if (mem_ready) begin
                c_word[m_base / 4 % 8][m_beats] = m_base + 16'(m_beats) + 16'h0100;
                m_beats++;
                if (m_beats == 4) begin
                    c_valid[m_base / 4 % 8] = 1;
                    c_tag[m_base / 4 % 8] = 11'(m_base / 32);
                    m_refill = 0; m_req = 0;
                    if (m_pend) m_pc = m_pend_pc;
                    m_pend = 0;
                end else begin
                    m_addr = m_base + 16'(m_beats);
                end
            end
        end
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check_eq("valid_out", valid_out, m_valid);
        check_eq("hit_fetch_out", hit_fetch_out, m_hit);
        check_eq("mem_req", bus.mem_req, m_req);
        if (m_valid) begin
            check_eq("instr_fetch_out", instr_fetch_out, m_instr);
            check_eq("pc_out", pc_out, m_pcout);
        end
        if (m_req) check_eq("mem_addr", bus.mem_addr, m_addr);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_until_valid();
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!valid_out && n < 40);
        check_eq("valid_timeout", valid_out, 1);
    endtask

    task automatic branch_to(input logic [15:0] target);
        pc_src = 1'b1;
        branch_target = target;
        cycle();
        pc_src = 1'b0;
    endtask

    logic [15:0] prev_pc, prev_instr;

    initial begin
        pc_src = 0; stall = 0; mem_ready = 0; branch_target = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("rst_valid", valid_out, 0);
        check_eq("rst_hit", hit_fetch_out, 0);
        check_eq("rst_instr", instr_fetch_out, 0);
        check_eq("rst_pc_out", pc_out, 0);
        check_eq("rst_mem_req", bus.mem_req, 0);
        check_eq("rst_mem_addr", bus.mem_addr, 0);
        rst_n = 1'b1;

        // Cold start
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check_eq("cold_req", bus.mem_req, 1);
            check_eq("cold_addr", bus.mem_addr, k);
        end
        cycle();
        check_eq("cold_req_drop", bus.mem_req, 0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            check_eq("cold_valid", valid_out, 1);
            check_eq("cold_hit", hit_fetch_out, 1);
            check_eq("cold_instr", instr_fetch_out, 16'h0100 + k);
            check_eq("cold_pc", pc_out, k);
        end
        cycle();
        check_eq("pc4_valid", valid_out, 0);
        check_eq("pc4_req", bus.mem_req, 1);
        check_eq("pc4_addr", bus.mem_addr, 16'h0004);
        repeat (4) cycle();

        // Conflict eviction of line 0
        branch_to(16'h0020);
        run_until_valid();
        check_eq("conf_instr", instr_fetch_out, 16'h0120);
        check_eq("conf_pc", pc_out, 16'h0020);
        branch_to(16'h0000);
        cycle();
        check_eq("conf_remiss_req", bus.mem_req, 1);
        check_eq("conf_remiss_addr", bus.mem_addr, 16'h0000);

        // Stall freezes outputs, no skip or duplicate afterwards
        run_until_valid();
        cycle();
        prev_pc = pc_out;
        prev_instr = instr_fetch_out;
        stall = 1'b1;
        repeat (3) begin
            cycle();
            check_eq("stall_pc", pc_out, prev_pc);
            check_eq("stall_instr", instr_fetch_out, prev_instr);
            check_eq("stall_valid", valid_out, 1);
        end
        stall = 1'b0;
        cycle();
        check_eq("stall_resume_pc", pc_out, prev_pc + 16'd1);

        // Branch during refill with slow memory
        branch_to(16'h0040);
        mem_ready = 1'b0;
        cycle();
        for (int i = 0; i < 8; i++) begin
            mem_ready = (i % 2 == 1);
            pc_src = (i == 3);
            branch_target = 16'h0009;
            cycle();
        end
        pc_src = 1'b0;
        mem_ready = 1'b1;
        check_eq("bir_done_req", bus.mem_req, 0);
        run_until_valid();
        check_eq("bir_pc", pc_out, 16'h0009);
        check_eq("bir_instr", instr_fetch_out, 16'h0109);

        // Reset in the middle of a refill
        branch_to(16'h0080);
        repeat (3) cycle();
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_req", bus.mem_req, 0);
        check_eq("mid_rst_valid", valid_out, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        check_eq("post_rst_req", bus.mem_req, 1);
        check_eq("post_rst_addr", bus.mem_addr, 16'h0000);
        run_until_valid();
        check_eq("post_rst_pc", pc_out, 16'h0000);

        // PC wrap
        branch_to(16'hFFFF);
        run_until_valid();
        check_eq("wrap_pc_hi", pc_out, 16'hFFFF);
        check_eq("wrap_instr_hi", instr_fetch_out, 16'h00FF);
        cycle();
        check_eq("wrap_valid", valid_out, 1);
        check_eq("wrap_pc_lo", pc_out, 16'h0000);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            pc_src = ($urandom_range(0, 9) == 0);
            branch_target = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                                         : 16'($urandom_range(0, 95));
            mem_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
